// File: rtl/inst_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | inst_loader: boot loader, byte stream -> 32-bit instruction BRAM writes.     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module inst_loader #(
  parameter int INST_SIZE = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 we,
  output logic [INST_SIZE-1:0] waddr,
  output logic [31:0]          wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] BODY = 2'd2;

  localparam logic [31:0]       CAP     = 32'd1 << INST_SIZE;
  localparam logic [INST_SIZE:0] REM_ONE = (INST_SIZE+1)'(1);

  logic [1:0]           state_q, state_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [23:0]          cnt_q, cnt_d;
  logic [23:0]          word_q, word_d;
  logic [INST_SIZE:0]   remain_q, remain_d;
  logic                 we_q, we_d;
  logic [INST_SIZE-1:0] waddr_q, waddr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  // Only the upper three bytes are stored; the fourth arrives on rx_data.
  logic [31:0] w_hdr;
  logic [31:0] w_word;
  assign w_hdr  = {cnt_q, rx_data};
  assign w_word = {word_q, rx_data};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    remain_d   = remain_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;

    // Address advances the edge after the write it labelled.
    if (we_q) begin
      waddr_d = waddr_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start && !busy_q) begin
          state_d    = HDR;
          byte_cnt_d = 2'd0;
          cnt_d      = 24'd0;
          waddr_d    = '0;
          err_d      = 1'b0;
          busy_d     = 1'b1;
        end
      end
      HDR: begin
        busy_d = 1'b1;
        if (rx_valid) begin
          cnt_d      = w_hdr[23:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (w_hdr > CAP) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else if (w_hdr == 32'd0) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              remain_d = w_hdr[INST_SIZE:0];
              state_d  = BODY;
            end
          end
        end
      end
      BODY: begin
        busy_d = 1'b1;
        if (rx_valid) begin
          word_d     = w_word[23:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            wdata_d  = w_word;
            we_d     = 1'b1;
            remain_d = remain_q - REM_ONE;
            if (remain_q == REM_ONE) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= 2'd0;
      cnt_q      <= 24'd0;
      word_q     <= 24'd0;
      remain_q   <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      remain_q   <= remain_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule
`default_nettype wire
